// File: rtl/fm_modulate_pkg.sv
// Shared fixed-point helpers and constants for the FM modulator slice.
package fm_modulate_pkg;

  localparam int BITS       = 10;
  localparam int PHASE_BITS = 16;
  localparam int LUT_DEPTH  = 257;

  function automatic logic [31:0] DEQUANTIZE(input logic [31:0] v);
    return $signed(v) >>> BITS;
  endfunction

  function automatic logic [31:0] QUANTIZE(input logic [31:0] v);
    return v << BITS;
  endfunction

  localparam logic [31:0] Q10_ONE = QUANTIZE(32'd1);

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } iq_t;

endpackage

// File: rtl/fm_modulate_sincos_lut.sv
// Quarter-wave sine table with quadrant folding to Q10 cos/sin.
module sincos_lut
  import fm_modulate_pkg::*;
(
  input  logic        clk,
  input  logic [15:0] phase,
  output logic [31:0] cos_q10,
  output logic [31:0] sin_q10
);

  // Elaboration-time sine in 2^28 fixed point (Taylor series), rounded to Q10.
  function automatic int quarter_sin(input int k);
    longint scale, pi_fx, x, term, sum;
    scale = 64'sd1 <<< 28;
    pi_fx = 64'sd843314857;
    x     = (longint'(k) * pi_fx) / 512;
    term  = x;
    sum   = x;
    for (int n = 1; n < 12; n++) begin
      term = (term * x) / scale;
      term = (term * x) / scale;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'((sum * 1024 + scale / 2) / scale);
  endfunction

  logic [10:0] tbl [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_tbl
    localparam int TV = quarter_sin(k);
    assign tbl[k] = 11'(TV);
  end

  // Address is registered, so the parent feeds the next-state phase.
  logic [9:0] addr_q;
  always_ff @(posedge clk) addr_q <= phase[15:6];

  logic unused_lsbs;
  assign unused_lsbs = ^phase[5:0];

  logic [8:0]  idx, idx_c;
  logic [31:0] t_i, t_c;
  assign idx   = {1'b0, addr_q[7:0]};
  assign idx_c = 9'd256 - idx;
  assign t_i   = {21'b0, tbl[idx]};
  assign t_c   = {21'b0, tbl[idx_c]};

  always_comb begin
    cos_q10 = t_c;
    sin_q10 = t_i;
    case (addr_q[9:8])
      2'd1: begin cos_q10 = -t_i; sin_q10 = t_c;  end
      2'd2: begin cos_q10 = -t_c; sin_q10 = -t_i; end
      2'd3: begin cos_q10 = t_i;  sin_q10 = -t_c; end
      default: ;
    endcase
  end

endmodule

// File: rtl/fm_modulate.sv
// Baseband FM modulator: audio -> phase accumulator -> cos/sin I/Q pair.
module fm_modulate
  import fm_modulate_pkg::*;
#(
  parameter logic [31:0] MOD_GAIN = 32'h00000400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_fifo_empty,
  output logic        input_rd_en,
  input  logic [31:0] audio_in,
  output logic [31:0] real_out,
  output logic [31:0] imag_out,
  output logic        wr_en_out,
  input  logic        out_fifos_full
);

  typedef logic [1:0] state_t;
  localparam state_t PREAMBLE = 2'd0;
  localparam state_t IDLE     = 2'd1;
  localparam state_t LOOKUP   = 2'd2;
  localparam state_t OUTPUT   = 2'd3;

  state_t          state_q, state_d;
  logic [15:0]     phase_q, phase_d, inc;
  iq_t             out_q, out_d;
  logic [31:0]     prod_lo, lut_cos, lut_sin;
  logic            rd, wr;

  // Low 32 bits of a signed product equal those of the unsigned product.
  assign prod_lo = audio_in * MOD_GAIN;
  assign inc     = 16'(DEQUANTIZE(prod_lo));

  sincos_lut u_lut (
    .clk     (clk),
    .phase   (phase_d),
    .cos_q10 (lut_cos),
    .sin_q10 (lut_sin)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    out_d   = out_q;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      PREAMBLE: begin
        out_d = '{re: Q10_ONE, im: 32'd0};
        if (!out_fifos_full) begin
          wr      = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: if (!input_fifo_empty) begin
        rd      = 1'b1;
        phase_d = phase_q + inc;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        out_d   = '{re: lut_cos, im: lut_sin};
        state_d = OUTPUT;
      end
      default: if (!out_fifos_full) begin
        wr      = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PREAMBLE;
      phase_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  // Preamble pair is visible from the first cycle out of reset.
  logic preamble;
  assign preamble    = (state_q == PREAMBLE) && !reset;
  assign real_out    = preamble ? Q10_ONE : out_q.re;
  assign imag_out    = preamble ? 32'd0   : out_q.im;
  assign input_rd_en = rd & ~reset;
  assign wr_en_out   = wr & ~reset;

endmodule

// File: doc/fm_modulate.md
# fm_modulate

Baseband FM modulator, the transmit-side counterpart of the `demodulate` stage. It reads one Q10 audio sample per transaction from an input FIFO and advances a 16-bit phase accumulator by a scaled version of that sample. It then writes the cosine/sine of the new phase as a Q10 I/Q pair into the real/imag output FIFOs. After each reset it emits one reference pair at phase 0, so a downstream demodulator has a previous sample before the first data sample arrives.

## Interface
- `MOD_GAIN`, default 32'h00000400: Q10 deviation gain. Default is 1.0, i.e. a phase step of 1 LSB per audio LSB.
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: asynchronous, active-high reset.
- `input_fifo_empty`  in  1: audio FIFO empty flag.
- `input_rd_en`  out  1: audio FIFO pop, first-word-fall-through; data is valid on `audio_in` while not empty.
- `audio_in`  in  32: signed Q10 audio sample.
- `real_out`  out  32: signed Q10 I sample (cos), registered.
- `imag_out`  out  32: signed Q10 Q sample (sin), registered.
- `wr_en_out`  out  1: push to both output FIFOs.
- `out_fifos_full`  in  1: OR of the real and imag FIFO full flags.

## Operation
- **Reset values:** `input_rd_en`=0, `wr_en_out`=0, `real_out`=0, `imag_out`=0, phase=16'h0000, state=PREAMBLE.
- **PREAMBLE:**
  - Drive `real_out`=32'h400, `imag_out`=0.
  - If `!out_fifos_full`, assert `wr_en_out` for 1 cycle and go to IDLE; otherwise stay.
  - No input is read in this state.
- **IDLE:**
  - If `!input_fifo_empty`: assert `input_rd_en` for 1 cycle, register phase ← phase + inc, go to LOOKUP.
  - inc = bits [15:0] of DEQUANTIZE((signed `audio_in` × signed `MOD_GAIN`)[31:0]).
  - Phase is unsigned mod 2^16, covering 2π. Wrap-around is natural; there is no saturation.
- **LOOKUP:**
  - Decompose the phase: q = phase[15:14], i = phase[13:6]; bits [5:0] are ignored (truncation, no interpolation).
  - Read table T[k] = round(1024·sin(πk/512)), k = 0..256 (257 entries, 11-bit unsigned).
  - Select by quadrant:
    - q0: cos = T[256−i], sin = T[i]
    - q1: cos = −T[i], sin = T[256−i]
    - q2: cos = −T[256−i], sin = −T[i]
    - q3: cos = T[i], sin = −T[256−i]
  - Sign-extend the results to 32 bits, register them into `real_out`/`imag_out`, go to OUTPUT.
- **OUTPUT:**
  - If `!out_fifos_full`: assert `wr_en_out` and go to IDLE; otherwise hold, with outputs stable.
  - `input_rd_en` stays 0 while in this state.
- `real_out`/`imag_out` change only on entry to PREAMBLE (reset) and in LOOKUP. Between writes they hold the last written pair.
- **Reset mid-operation:** the in-flight sample is discarded and the phase returns to 0. The preamble pair is emitted again.

## Timing
- **Latency:** `input_rd_en` in cycle N → LOOKUP in N+1 → OUTPUT in N+2. `wr_en_out` is asserted in N+2 if the output FIFOs are not full.
- **Throughput:** at most 1 sample per 3 cycles.
- **Preamble:** with `out_fifos_full`=0, the preamble `wr_en_out` is asserted in the first cycle after reset deasserts.
- `input_rd_en` and `wr_en_out` are never asserted in the same cycle.
- **Full-flag sampling:** `out_fifos_full` is sampled combinationally in OUTPUT/PREAMBLE. If it rises in the same cycle, `wr_en_out` is suppressed in that cycle.
- **Empty-flag sampling:** `input_fifo_empty` is sampled combinationally in IDLE only.

## Structure
- **`globals.sv`:** DEQUANTIZE/QUANTIZE (BITS=10), plus the new constants `PHASE_BITS`=16 and `LUT_DEPTH`=257.
- **Local state enum:** PREAMBLE, IDLE, LOOKUP, OUTPUT, typedef'd as `state_t` inside the module.
- **Sub-module `sincos_lut`:**
  - Ports: `clk`, `phase[15:0]` in; `cos_q10[31:0]`, `sin_q10[31:0]` out.
  - Holds the constant quarter-wave table and performs the quadrant folding combinationally.
  - The parent module registers its outputs in LOOKUP.

## Test plan
- **Preamble:** reset, FIFOs idle → exactly one write of (0x00000400, 0x00000000), then no writes while the input is empty.
- **Zero audio:** four samples of 0 → four writes of (0x400, 0); phase remains 0x0000.
- **Quarter steps:** 16384 (16.0 Q10) ×4 with the default gain.
  - Writes (0, 0x400), (0xFFFFFC00, 0), (0, 0xFFFFFC00), (0x400, 0).
  - Phase wraps from 0xC000 to 0x0000.
- **Negative step:** from reset, audio −16384 → phase 0xC000 → write (0, 0xFFFFFC00).
- **Backpressure:** hold `out_fifos_full` for 5 cycles while in OUTPUT.
  - No `wr_en_out` and no `input_rd_en` during the hold; outputs stable.
  - A single write in the cycle after release.
- **Reset in LOOKUP:** assert reset one cycle after a read.
  - No write for that sample; next write is the preamble pair.
  - A following 0 sample yields (0x400, 0).
- **Loopback:** chain into `demodulate` with a ramp input → the demodulated output tracks the ramp within LUT-truncation error.
